// File: rtl/multiplier_pkg.sv
// Types shared by the Montgomery multiplier/encoder blocks.
//   enc_state_e : FSM states of montgomery_encode
package multiplier_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReduce,
    StShift,
    StDone
  } enc_state_e;

endpackage

// File: rtl/params_pkg.sv
// Shared arithmetic parameters for the Montgomery blocks (Dilithium modulus).
//   DATA_LENGTH    : operand/result width in bits
//   MODULUS        : q = 2^23 - 2^13 + 1
//   MODULUS_LENGTH : bit length of q (log2 R)
//   MOD_INV        : q^-1 mod 2^MODULUS_LENGTH
package params_pkg;

  parameter int unsigned DATA_LENGTH    = 24;
  parameter int unsigned MODULUS        = 8380417;
  parameter int unsigned MODULUS_LENGTH = 23;
  parameter int unsigned MOD_INV        = 8193;

endpackage

// File: rtl/mod_dbl_step.sv
// One shift/conditional-subtract step: r_o = (2r + bit) mod m, given r < m.
// Ports:
//   r_i   : current accumulator (DATA_LENGTH+1 bits)
//   bit_i : bit shifted in (0 in the doubling phase)
//   m_i   : modulus
//   r_o   : next accumulator
module mod_dbl_step #(
  parameter int unsigned DATA_LENGTH = params_pkg::DATA_LENGTH
) (
  input  logic [DATA_LENGTH:0]   r_i,
  input  logic                   bit_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic [DATA_LENGTH:0]   r_o
);

  logic [DATA_LENGTH:0] t;
  logic [DATA_LENGTH:0] m_ext;
  // With r < m < 2^DATA_LENGTH the accumulator MSB is always zero, so 2r+bit
  // fits in DATA_LENGTH+1 bits and the MSB can be dropped.
  logic                 unused_r_msb;

  assign unused_r_msb = r_i[DATA_LENGTH];

  always_comb begin
    t     = {r_i[DATA_LENGTH-1:0], bit_i};
    m_ext = {1'b0, m_i};
    r_o   = (t >= m_ext) ? (t - m_ext) : t;
  end

endmodule

// File: rtl/montgomery_encode.sv
// Bit-serial conversion of x into Montgomery form: result = x * 2^m_bl mod m.
// REDUCE folds x (MSB first) into x mod m, SHIFT doubles m_bl times mod m.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset
//   start_i  : request, sampled only in IDLE
//   x_i      : value to encode
//   m_i      : modulus (nonzero, m < 2^m_bl)
//   m_bl_i   : modulus bit length, 0..DATA_LENGTH
//   result_o : x * 2^m_bl mod m, held until the next result
//   valid_o  : one-cycle pulse while in DONE
//   busy_o   : high from accept through DONE
module montgomery_encode
  import multiplier_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = params_pkg::DATA_LENGTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   busy_o
);

  enc_state_e             state_q, state_d;
  logic [DATA_LENGTH-1:0] cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] x_q, x_d;
  logic [DATA_LENGTH-1:0] m_q, m_d;
  logic [DATA_LENGTH-1:0] m_bl_q, m_bl_d;
  logic [DATA_LENGTH:0]   r_q, r_d;
  logic [DATA_LENGTH-1:0] result_q, result_d;

  logic                   step_bit;
  logic [DATA_LENGTH:0]   r_step;

  // x_q is shifted left each REDUCE step, so its MSB is always the next bit.
  assign step_bit = (state_q == StReduce) ? x_q[DATA_LENGTH-1] : 1'b0;

  mod_dbl_step #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_step (
    .r_i  (r_q),
    .bit_i(step_bit),
    .m_i  (m_q),
    .r_o  (r_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    m_d      = m_q;
    m_bl_d   = m_bl_q;
    r_d      = r_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StReduce;
          x_d     = x_i;
          m_d     = m_i;
          m_bl_d  = m_bl_i;
          r_d     = '0;
          cnt_d   = DATA_LENGTH'(DATA_LENGTH - 1);
        end
      end
      StReduce: begin
        r_d   = r_step;
        x_d   = x_q << 1;
        cnt_d = cnt_q - DATA_LENGTH'(1);
        if (cnt_q == '0) begin
          if (m_bl_q == '0) begin
            state_d  = StDone;
            result_d = r_step[DATA_LENGTH-1:0];
            cnt_d    = '0;
          end else begin
            state_d = StShift;
            cnt_d   = m_bl_q - DATA_LENGTH'(1);
          end
        end
      end
      StShift: begin
        r_d   = r_step;
        cnt_d = cnt_q - DATA_LENGTH'(1);
        if (cnt_q == '0) begin
          state_d  = StDone;
          result_d = r_step[DATA_LENGTH-1:0];
          cnt_d    = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      x_q      <= '0;
      m_q      <= '0;
      m_bl_q   <= '0;
      r_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      m_q      <= m_d;
      m_bl_q   <= m_bl_d;
      r_q      <= r_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;
  assign valid_o  = (state_q == StDone);
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_montgomery_encode.sv
// Scoreboard bench for montgomery_encode: expected results are queued at
// issue time and popped by a monitor on each valid_o pulse.
module tb_montgomery_encode;

  localparam int unsigned Dl = params_pkg::DATA_LENGTH;
  localparam logic [Dl-1:0] Q = Dl'(8380417);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [Dl-1:0] x, m, m_bl;
  logic [Dl-1:0] result;
  logic          valid, busy;

  always #5 clk = ~clk;

  montgomery_encode #(
    .DATA_LENGTH(Dl)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .x_i     (x),
    .m_i     (m),
    .m_bl_i  (m_bl),
    .result_o(result),
    .valid_o (valid),
    .busy_o  (busy)
  );

  int            total = 0;
  int            bad   = 0;
  logic [Dl-1:0] exp_q[$];
  logic [Dl-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst !== 1'b1 && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", 64'(result), 64'(mon_exp));
      end
    end
  end

  task automatic issue(input logic [Dl-1:0] xv, mv, mbv, expv);
    @(negedge clk);
    x     = xv;
    m     = mv;
    m_bl  = mbv;
    start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble inputs to show the operands were latched.
    x     = Dl'($urandom);
    m     = Dl'($urandom);
    m_bl  = Dl'($urandom);
  endtask

  // Counts negedges until valid_o is seen; 0 means the bound expired.
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input string name, input logic [Dl-1:0] xv, mv, mbv, expv);
    int n;
    issue(xv, mv, mbv, expv);
    wait_valid(n);
    check({name, "_latency"}, 64'(n), 64'(Dl + int'(mbv) + 1));
    check({name, "_busy_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({name, "_idle_after"}, 64'({busy, valid}), 64'd0);
  endtask

  initial begin
    int          n, n2;
    logic [Dl-1:0] rx;
    longint      e;

    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    m     = '0;
    m_bl  = '0;
    #1;
    check("reset_outputs", 64'({result, valid, busy}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op("q_x1",     Dl'(1),       Q,      Dl'(23), Dl'(8191));
    do_op("q_x0",     Dl'(0),       Q,      Dl'(23), Dl'(0));
    do_op("q_xq",     Q,            Q,      Dl'(23), Dl'(0));
    do_op("q_xq1",    Dl'(8380418), Q,      Dl'(23), Dl'(8191));
    do_op("m13_x5",   Dl'(5),       Dl'(13), Dl'(4), Dl'(2));
    do_op("m13_bl0",  Dl'(40),      Dl'(13), Dl'(0), Dl'(1));

    // start while busy is ignored and not queued
    issue(Dl'(1), Q, Dl'(23), Dl'(8191));
    repeat (5) @(negedge clk);
    x     = Dl'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);
    check("ignore_latency", 64'(n + 6), 64'(Dl + 24));
    repeat (Dl + 30) @(negedge clk);
    check("ignore_no_requeue", 64'(busy), 64'd0);

    // held start: one result per Dl + m_bl + 2 cycles, no accept in DONE
    @(negedge clk);
    x     = Dl'(5);
    m     = Dl'(13);
    m_bl  = Dl'(4);
    start = 1'b1;
    exp_q.push_back(Dl'(2));
    exp_q.push_back(Dl'(2));
    wait_valid(n);
    check("b2b_first_latency", 64'(n), 64'(Dl + 5));
    @(negedge clk);
    check("b2b_idle_gap", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_valid(n2);
    check("b2b_period", 64'(n2 + 1), 64'(Dl + 6));
    @(negedge clk);

    // reset in REDUCE aborts with no pulse
    issue(Dl'(1), Q, Dl'(23), Dl'(8191));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", 64'({result, valid, busy}), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (Dl + 40) @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);
    do_op("after_abort_x2", Dl'(2), Q, Dl'(23), Dl'(16382));

    // a few random operands against an arithmetic model
    for (int i = 0; i < 8; i++) begin
      rx = Dl'($urandom);
      e  = ((longint'(rx) % 64'd8380417) << 23) % 64'd8380417;
      do_op("rand_q", rx, Q, Dl'(23), Dl'(e));
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
